// File: rtl/ro_sample_sequencer.sv
// Ring-oscillator sample sequencer: times the sensor clear/enable/settle windows, captures
// monitor_count after each window and streams results out of a small valid/ready FIFO.
module ro_sample_sequencer #(
  parameter int unsigned WINDOW_CYCLES = 256,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned SAMPLE_WIDTH  = 36
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [15:0]             i_num_samples,
  output logic                    o_ro_enable,
  output logic                    o_ro_reset,
  input  logic [SAMPLE_WIDTH-1:0] i_monitor_count,
  output logic [SAMPLE_WIDTH-1:0] o_sample_data,
  output logic                    o_sample_valid,
  input  logic                    i_sample_ready,
  output logic                    o_busy,
  output logic                    o_overflow,
  output logic [15:0]             o_samples_taken
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned M1 = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned M2 = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
  localparam int unsigned CW = $clog2(M2 + 1);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   occ_t;

  localparam cnt_t WinLoad = cnt_t'(WINDOW_CYCLES - 1);
  localparam cnt_t SetLoad = cnt_t'(SETTLE_CYCLES - 1);
  localparam cnt_t GapLoad = (GAP_CYCLES == 0) ? cnt_t'(0) : cnt_t'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StWindow, StSettle, StCapture, StGap
  } state_t;

  state_t r_state, w_state_d;
  cnt_t   r_cnt, w_cnt_d;
  logic   r_stop_pend, w_stop_pend_d;
  logic   w_capture, w_start_run, w_last;
  logic [15:0] r_num, r_taken, w_taken_inc;
  logic   r_overflow, r_ro_enable, r_ro_reset, r_busy;

  logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] r_head, w_head_d;
  ptr_t r_wr_ptr, r_rd_ptr, w_rd_nxt;
  occ_t r_occ, w_occ_d;
  logic r_valid, w_pop, w_push, w_full;

  assign w_taken_inc = r_taken + 16'd1;
  assign w_last      = (r_num != 16'd0) && (w_taken_inc == r_num);

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_stop_pend_d = r_stop_pend;
    w_capture     = 1'b0;
    w_start_run   = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d     = StClear;
          w_cnt_d       = cnt_t'(1);
          w_stop_pend_d = 1'b0;
          w_start_run   = 1'b1;
        end
      end
      StClear: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (r_cnt == '0) begin
          w_state_d = StWindow;
          w_cnt_d   = WinLoad;
        end else begin
          w_cnt_d = r_cnt - cnt_t'(1);
        end
      end
      StWindow: begin
        if (i_stop) w_stop_pend_d = 1'b1;
        if (r_cnt == '0) begin
          w_state_d = StSettle;
          w_cnt_d   = SetLoad;
        end else begin
          w_cnt_d = r_cnt - cnt_t'(1);
        end
      end
      StSettle: begin
        if (i_stop) w_stop_pend_d = 1'b1;
        if (r_cnt == '0) begin
          w_state_d = StCapture;
        end else begin
          w_cnt_d = r_cnt - cnt_t'(1);
        end
      end
      StCapture: begin
        w_capture = 1'b1;
        if (w_last || r_stop_pend || i_stop) begin
          w_state_d = StIdle;
        end else if (GAP_CYCLES == 0) begin
          w_state_d = StWindow;
          w_cnt_d   = WinLoad;
        end else begin
          w_state_d = StGap;
          w_cnt_d   = GapLoad;
        end
      end
      StGap: begin
        if (i_stop) begin
          w_state_d = StIdle;
        end else if (r_cnt == '0) begin
          w_state_d = StWindow;
          w_cnt_d   = WinLoad;
        end else begin
          w_cnt_d = r_cnt - cnt_t'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with the state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_num       <= '0;
      r_taken     <= '0;
      r_overflow  <= 1'b0;
      r_ro_enable <= 1'b0;
      r_ro_reset  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_stop_pend <= w_stop_pend_d;
      r_ro_enable <= (w_state_d == StWindow);
      r_ro_reset  <= (w_state_d == StClear);
      r_busy      <= (w_state_d != StIdle);
      if (w_start_run) begin
        r_num      <= i_num_samples;
        r_taken    <= '0;
        r_overflow <= 1'b0;
      end else if (w_capture) begin
        r_taken <= w_taken_inc;
        if (!w_push) r_overflow <= 1'b1;
      end
    end
  end

  assign w_pop    = r_valid & i_sample_ready;
  assign w_full   = (r_occ == occ_t'(FIFO_DEPTH));
  assign w_push   = w_capture & (~w_full | w_pop);
  assign w_rd_nxt = w_pop ? (r_rd_ptr + ptr_t'(1)) : r_rd_ptr;

  always_comb begin
    w_occ_d = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_d = r_occ + occ_t'(1);
      2'b01:   w_occ_d = r_occ - occ_t'(1);
      default: w_occ_d = r_occ;
    endcase
    // A push landing on the next read slot bypasses the array so the head is never stale.
    if (w_push && (r_wr_ptr == w_rd_nxt)) w_head_d = i_monitor_count;
    else                                  w_head_d = r_mem[w_rd_nxt];
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_monitor_count;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      r_rd_ptr <= w_rd_nxt;
      r_occ    <= w_occ_d;
      r_valid  <= (w_occ_d != '0);
      r_head   <= w_head_d;
    end
  end

  assign o_ro_enable     = r_ro_enable;
  assign o_ro_reset      = r_ro_reset;
  assign o_busy          = r_busy;
  assign o_overflow      = r_overflow;
  assign o_samples_taken = r_taken;
  assign o_sample_valid  = r_valid;
  assign o_sample_data   = r_head;

endmodule

// File: tb/tb_ro_sample_sequencer.sv
// Directed bench for ro_sample_sequencer with a simple sensor model (fixed value or
// base + enable-pulse count).
module tb_ro_sample_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, stop, ready;
  logic [15:0] num;
  logic        en, rr, valid, busy, ovf;
  logic [35:0] mon, data;
  logic [15:0] taken;

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0, en_edges = 0, rr_edges = 0;
  int   rise_at [64];
  logic prev_en = 1'b0, prev_rr = 1'b0;
  logic        mon_fixed = 1'b1;
  logic [35:0] mon_val = '0, mon_base = '0;

  ro_sample_sequencer dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_stop         (stop),
    .i_num_samples  (num),
    .o_ro_enable    (en),
    .o_ro_reset     (rr),
    .i_monitor_count(mon),
    .o_sample_data  (data),
    .o_sample_valid (valid),
    .i_sample_ready (ready),
    .o_busy         (busy),
    .o_overflow     (ovf),
    .o_samples_taken(taken)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_en <= en;
    prev_rr <= rr;
    if (en && !prev_en) begin
      rise_at[en_edges % 64] <= cyc;
      en_edges <= en_edges + 1;
    end
    if (rr && !prev_rr) rr_edges <= rr_edges + 1;
  end

  always_comb mon = mon_fixed ? mon_val : (mon_base + 36'(en_edges));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0; num = '0;
    repeat (3) tick();
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", en); end
    n_cmp++; if (rr !== 1'b0) begin n_bad++; $display("FAIL reset_rr: got %b want 0", rr); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (data !== 36'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (taken !== 16'd0) begin n_bad++; $display("FAIL reset_taken: got %0d want 0", taken); end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_shot;
    int e0, r0;
    mon_fixed = 1'b1; mon_val = 36'h0_0000_1234; num = 16'd1; ready = 1'b0;
    e0 = en_edges; r0 = rr_edges;
    pulse_start();  // now in cycle 1
    n_cmp++; if (rr !== 1'b1) begin n_bad++; $display("FAIL ss_rr_c1: got %b want 1", rr); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ss_busy_c1: got %b want 1", busy); end
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL ss_en_c1: got %b want 0", en); end
    tick();
    n_cmp++; if (rr !== 1'b1) begin n_bad++; $display("FAIL ss_rr_c2: got %b want 1", rr); end
    tick();
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL ss_en_c3: got %b want 1", en); end
    n_cmp++; if (rr !== 1'b0) begin n_bad++; $display("FAIL ss_rr_c3: got %b want 0", rr); end
    repeat (255) tick();
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL ss_en_c258: got %b want 1", en); end
    tick();
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL ss_en_c259: got %b want 0", en); end
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ss_busy_c263: got %b want 1", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ss_valid_c263: got %b want 0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ss_valid_c264: got %b want 1", valid); end
    n_cmp++; if (data !== 36'h0_0000_1234) begin n_bad++; $display("FAIL ss_data: got %h want 000001234", data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ss_busy_c264: got %b want 0", busy); end
    n_cmp++; if (taken !== 16'd1) begin n_bad++; $display("FAIL ss_taken: got %0d want 1", taken); end
    n_cmp++; if (rr_edges - r0 !== 1) begin n_bad++; $display("FAIL ss_rr_pulses: got %0d want 1", rr_edges - r0); end
    n_cmp++; if (en_edges - e0 !== 1) begin n_bad++; $display("FAIL ss_en_pulses: got %0d want 1", en_edges - e0); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ss_valid_after_pop: got %b want 0", valid); end
  endtask

  task automatic test_multi_sample;
    int e0, r0;
    logic [35:0] got [$];
    mon_fixed = 1'b0; mon_base = 36'h5_0000_0000; num = 16'd3; ready = 1'b1;
    e0 = en_edges; r0 = rr_edges;
    pulse_start();
    for (int i = 0; i < 1500 && (busy || valid); i++) begin
      if (valid && ready) got.push_back(data);
      tick();
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ms_timeout_busy: got %b want 0", busy); end
    n_cmp++; if (got.size() !== 3) begin n_bad++; $display("FAIL ms_count: got %0d want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      n_cmp++;
      if (got[k] !== mon_base + 36'(e0 + k + 1)) begin
        n_bad++; $display("FAIL ms_data%0d: got %h want %h", k, got[k], mon_base + 36'(e0 + k + 1));
      end
    end
    n_cmp++;
    if (rise_at[(e0 + 1) % 64] - rise_at[e0 % 64] !== 277) begin
      n_bad++; $display("FAIL ms_period1: got %0d want 277", rise_at[(e0 + 1) % 64] - rise_at[e0 % 64]);
    end
    n_cmp++;
    if (rise_at[(e0 + 2) % 64] - rise_at[(e0 + 1) % 64] !== 277) begin
      n_bad++; $display("FAIL ms_period2: got %0d want 277", rise_at[(e0 + 2) % 64] - rise_at[(e0 + 1) % 64]);
    end
    n_cmp++; if (rr_edges - r0 !== 1) begin n_bad++; $display("FAIL ms_clears: got %0d want 1", rr_edges - r0); end
    n_cmp++; if (en_edges - e0 !== 3) begin n_bad++; $display("FAIL ms_windows: got %0d want 3", en_edges - e0); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure_stop_gap;
    int e0;
    mon_fixed = 1'b0; mon_base = 36'h7_0000_0000; num = 16'd0; ready = 1'b0;
    e0 = en_edges;
    pulse_start();
    for (int i = 0; i < 6000 && !ovf; i++) tick();
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL bp_overflow: got %b want 1", ovf); end
    n_cmp++; if (taken !== 16'd17) begin n_bad++; $display("FAIL bp_taken: got %0d want 17", taken); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy_gap: got %b want 1", busy); end
    stop = 1'b1;  // first GAP cycle
    tick();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_stop_busy: got %b want 0", busy); end
    repeat (300) tick();
    n_cmp++; if (taken !== 16'd17) begin n_bad++; $display("FAIL gap_stop_taken: got %0d want 17", taken); end
    n_cmp++; if (en_edges - e0 !== 17) begin n_bad++; $display("FAIL gap_stop_windows: got %0d want 17", en_edges - e0); end
    ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      n_cmp++;
      if (valid !== 1'b1 || data !== mon_base + 36'(e0 + k)) begin
        n_bad++; $display("FAIL bp_drain%0d: got v=%b %h want v=1 %h", k, valid, data, mon_base + 36'(e0 + k));
      end
      tick();
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain_empty: got %b want 0", valid); end
    ready = 1'b0;
  endtask

  task automatic test_full_simultaneous_pop;
    int e0, cnt;
    mon_fixed = 1'b0; mon_base = 36'h9_0000_0000; num = 16'd0; ready = 1'b0;
    e0 = en_edges;
    pulse_start();
    for (int i = 0; i < 6000 && taken != 16'd16; i++) tick();
    n_cmp++; if (taken !== 16'd16) begin n_bad++; $display("FAIL fp_taken16: got %0d want 16", taken); end
    for (int i = 0; i < 400 && !en; i++) tick();
    for (int i = 0; i < 300 && en; i++) tick();
    repeat (4) tick();  // now in CAPTURE of sample 17
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL fp_overflow: got %b want 0", ovf); end
    n_cmp++; if (taken !== 16'd17) begin n_bad++; $display("FAIL fp_taken17: got %0d want 17", taken); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fp_stop_busy: got %b want 0", busy); end
    ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid) begin
        n_cmp++;
        if (data !== mon_base + 36'(e0 + 2 + cnt)) begin
          n_bad++; $display("FAIL fp_data%0d: got %h want %h", cnt, data, mon_base + 36'(e0 + 2 + cnt));
        end
        cnt++;
      end
      tick();
    end
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL fp_occupancy: got %0d want 16", cnt); end
    ready = 1'b0;
  endtask

  task automatic test_stop_window;
    int e0, n;
    mon_fixed = 1'b0; mon_base = 36'hB_0000_0000; num = 16'd0; ready = 1'b0;
    e0 = en_edges;
    pulse_start();
    for (int i = 0; i < 10 && !en; i++) tick();
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL sw_en_rise: got %b want 1", en); end
    n = 0;
    for (int i = 0; i < 400 && en; i++) begin
      n++;
      stop = (n == 10);
      tick();
    end
    stop = 1'b0;
    n_cmp++; if (n !== 256) begin n_bad++; $display("FAIL sw_window_len: got %0d want 256", n); end
    for (int i = 0; i < 20 && busy; i++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sw_busy: got %b want 0", busy); end
    n_cmp++; if (taken !== 16'd1) begin n_bad++; $display("FAIL sw_taken: got %0d want 1", taken); end
    n_cmp++;
    if (valid !== 1'b1 || data !== mon_base + 36'(e0 + 1)) begin
      n_bad++; $display("FAIL sw_sample: got v=%b %h want v=1 %h", valid, data, mon_base + 36'(e0 + 1));
    end
    repeat (300) tick();
    n_cmp++; if (en_edges - e0 !== 1) begin n_bad++; $display("FAIL sw_no_restart: got %0d want 1", en_edges - e0); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL sw_pop: got %b want 0", valid); end
  endtask

  task automatic test_reset_mid_window;
    int c;
    mon_fixed = 1'b1; mon_val = 36'h0_0000_0ABC; num = 16'd1; ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 400 && busy; i++) tick();
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rm_prefill: got %b want 1", valid); end
    num = 16'd0;
    pulse_start();
    for (int i = 0; i < 10 && !en; i++) tick();
    repeat (20) tick();
    n_cmp++; if (en !== 1'b1) begin n_bad++; $display("FAIL rm_in_window: got %b want 1", en); end
    rst = 1'b1;
    #1;
    n_cmp++; if (en !== 1'b0) begin n_bad++; $display("FAIL rm_en: got %b want 0", en); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (taken !== 16'd0) begin n_bad++; $display("FAIL rm_taken: got %0d want 0", taken); end
    n_cmp++; if (data !== 36'h0) begin n_bad++; $display("FAIL rm_data: got %h want 0", data); end
    tick();
    rst = 1'b0;
    tick();
    mon_val = 36'h0_0000_0DEF; num = 16'd1;
    pulse_start();  // cycle 1
    n_cmp++; if (rr !== 1'b1) begin n_bad++; $display("FAIL rm_restart_clear: got %b want 1", rr); end
    c = 1;
    while (!valid && c < 400) begin
      tick();
      c++;
    end
    n_cmp++; if (c !== 264) begin n_bad++; $display("FAIL rm_restart_latency: got %0d want 264", c); end
    n_cmp++; if (data !== 36'h0_0000_0DEF) begin n_bad++; $display("FAIL rm_restart_data: got %h want 000000def", data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_restart_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_multi_sample();
    test_backpressure_stop_gap();
    test_full_simultaneous_pop();
    test_stop_window();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
